// File: rtl/multibyte_add_sequencer.sv
// rtl/multibyte_add_sequencer.sv - multi-byte add/subtract sequenced over an external 8-bit adder
//
// Feeds one byte per clock, LSB first, through an external combinational
// 8-bit adder, rippling the carry in c_reg.
// Fixed latency: res_valid rises NBYTES clocks after the accept edge.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   op_valid/op_ready             operand request handshake (ready only in IDLE)
//   op_a, op_b                    operands, 8*NBYTES bits
//   op_cin                        carry-in, used for addition only
//   op_sub                        1: A-B, 0: A+B+cin
//   add_a, add_b, add_cin         byte operands to the external adder (0 outside ADD)
//   add_s, add_cout               sum/carry returned by the external adder
//   res_valid/res_ready           result handshake
//   res_sum, res_cout, res_ovf    result, final carry (1 = no borrow on sub), signed overflow
//   busy                          high in any state other than IDLE
module multibyte_add_sequencer #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  op_cin,
  input  logic                  op_sub,
  output logic [7:0]            add_a,
  output logic [7:0]            add_b,
  output logic                  add_cin,
  input  logic [7:0]            add_s,
  input  logic                  add_cout,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [8*NBYTES-1:0]   res_sum,
  output logic                  res_cout,
  output logic                  res_ovf,
  output logic                  busy
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    sum_reg;
  logic            c_reg;

  // Bit offset of the current byte lane.
  logic [IW+2:0]   lane_base;
  assign lane_base = {idx, 3'b000};

  logic            in_add;
  logic            in_done;
  assign in_add  = (state == ADD);
  assign in_done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      sum_reg <= '0;
      c_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            // Subtraction is A + ~B + 1: invert B and force the carry-in.
            a_reg <= op_a;
            b_reg <= op_sub ? ~op_b : op_b;
            c_reg <= op_sub | op_cin;
            idx   <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          sum_reg[lane_base +: 8] <= add_s;
          c_reg                   <= add_cout;
          idx                     <= idx + 1'b1;
          if (idx == IW'(NBYTES - 1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          // No accept on this edge: the next request waits for IDLE.
          if (res_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign add_a   = in_add ? a_reg[lane_base +: 8] : 8'h00;
  assign add_b   = in_add ? b_reg[lane_base +: 8] : 8'h00;
  assign add_cin = in_add & c_reg;

  assign op_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign res_valid = in_done;

  // Results are held by the registers until the DONE-to-IDLE edge.
  assign res_sum  = in_done ? sum_reg : '0;
  assign res_cout = in_done & c_reg;
  assign res_ovf  = in_done & (a_reg[W-1] == b_reg[W-1]) & (sum_reg[W-1] != a_reg[W-1]);

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// tb/tb_multibyte_add_sequencer.sv - self-checking bench for multibyte_add_sequencer
module tb_multibyte_add_sequencer;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
  localparam longint UMOD = 64'sd4294967296;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          op_valid;
  logic          op_ready;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          op_cin;
  logic          op_sub;
  logic [7:0]    add_a;
  logic [7:0]    add_b;
  logic          add_cin;
  logic [7:0]    add_s;
  logic          add_cout;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_sum;
  logic          res_cout;
  logic          res_ovf;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // External 8-bit ripple adder.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

  multibyte_add_sequencer #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
    .op_sub    (op_sub),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_ovf   (res_ovf),
    .busy      (busy)
  );

  // Reference: plain integer arithmetic. Returns {ovf, cout, sum}.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sub, input logic cin);
    longint ua, ub, sa, sb, ures, sres;
    logic   co, ov;
    logic [63:0] ubits;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      ures = ua - ub;
      sres = sa - sb;
      co   = (ua >= ub);
    end else begin
      ures = ua + ub + longint'(cin);
      sres = sa + sb + longint'(cin);
      co   = (ures >= UMOD);
    end
    ov    = (sres > SMAX) || (sres < SMIN);
    ubits = ures;
    return {ov, co, ubits[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'hFFFFFFFF;
      1:       v = 32'h7FFFFFFF;
      2:       v = 32'h80000000;
      3:       v = 32'h00000000;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Issues one request and waits for its result; lat = edges from accept to res_valid.
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic cin, output logic [W-1:0] s, output logic co,
                         output logic ov, output int lat);
    int g;
    op_a = a; op_b = b; op_sub = sub; op_cin = cin; op_valid = 1'b1;
    g = 0;
    while (!op_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    @(posedge clk); #1;
    op_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (g >= 50) lat = 999;
    s = res_sum; co = res_cout; ov = res_ovf;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (!op_ready && g < 50) begin
      @(posedge clk); #1; g++;
    end
    total++;
    if (!op_ready) begin
      bad++; $display("FAIL wait_idle: op_ready=%0b required 1", op_ready);
    end
  endtask

  task automatic test_reset();
    op_valid = 1'b0; op_a = '0; op_b = '0; op_cin = 1'b0; op_sub = 1'b0; res_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, res_valid, res_cout, res_ovf} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: busy/valid/cout/ovf=%b required 0000",
                      {busy, res_valid, res_cout, res_ovf});
    end
    total++;
    if (op_ready !== 1'b1) begin
      bad++; $display("FAIL reset_op_ready: got %0b required 1", op_ready);
    end
    total++;
    if (res_sum !== '0 || {add_a, add_b, add_cin} !== 17'd0) begin
      bad++; $display("FAIL reset_data: res_sum=%h add=%h required 0", res_sum, {add_a, add_b, add_cin});
    end
    // Requests during reset must not be taken.
    op_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL reset_hold_busy: got %0b required 0", busy);
    end
    op_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    logic         tsub [4];
    logic [W-1:0] es [4];
    logic         eco [4];
    logic         eov [4];
    logic [W-1:0] s;
    logic         co, ov;
    int           lat;
    ta[0] = 32'h000000FF; tb[0] = 32'h00000001; tsub[0] = 0; es[0] = 32'h00000100; eco[0] = 0; eov[0] = 0;
    ta[1] = 32'hFFFFFFFF; tb[1] = 32'h00000001; tsub[1] = 0; es[1] = 32'h00000000; eco[1] = 1; eov[1] = 0;
    ta[2] = 32'h7FFFFFFF; tb[2] = 32'h00000001; tsub[2] = 0; es[2] = 32'h80000000; eco[2] = 0; eov[2] = 1;
    ta[3] = 32'h00000005; tb[3] = 32'h00000007; tsub[3] = 1; es[3] = 32'hFFFFFFFE; eco[3] = 0; eov[3] = 0;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_idle();
      run_txn(ta[i], tb[i], tsub[i], 1'b0, s, co, ov, lat);
      total++;
      if (lat !== NBYTES) begin
        bad++; $display("FAIL directed%0d_latency: got %0d required %0d", i, lat, NBYTES);
      end
      total++;
      if ({ov, co, s} !== {eov[i], eco[i], es[i]}) begin
        bad++; $display("FAIL directed%0d_result: got sum=%h cout=%0b ovf=%0b required sum=%h cout=%0b ovf=%0b",
                        i, s, co, ov, es[i], eco[i], eov[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, s;
    logic         sub, cin, co, ov;
    logic [W+1:0] exp_r;
    int           lat;
    res_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a = rnd_word(); b = rnd_word();
      sub = 1'($urandom_range(0, 1)); cin = 1'($urandom_range(0, 1));
      exp_r = ref_model(a, b, sub, cin);
      wait_idle();
      run_txn(a, b, sub, cin, s, co, ov, lat);
      total++;
      if (lat !== NBYTES || {ov, co, s} !== exp_r) begin
        bad++; $display("FAIL random%0d: a=%h b=%h sub=%0b cin=%0b got lat=%0d {ovf,cout,sum}=%h required lat=%0d %h",
                        i, a, b, sub, cin, lat, {ov, co, s}, NBYTES, exp_r);
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] a, b, s;
    logic         co, ov;
    logic [W+1:0] exp_r;
    int           lat;
    int           errs;
    a = $urandom; b = $urandom;
    exp_r = ref_model(a, b, 1'b0, 1'b1);
    wait_idle();
    res_ready = 1'b0;
    run_txn(a, b, 1'b0, 1'b1, s, co, ov, lat);
    total++;
    if ({ov, co, s} !== exp_r) begin
      bad++; $display("FAIL stall_result: got %h required %h", {ov, co, s}, exp_r);
    end
    op_a = $urandom; op_b = $urandom; op_sub = 1'b1; op_valid = 1'b1;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b1 || op_ready !== 1'b0 || {res_ovf, res_cout, res_sum} !== exp_r) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL stall_hold: %0d unstable cycles (last valid=%0b ready=%0b res=%h) required 0 (res=%h)",
                      errs, res_valid, op_ready, {res_ovf, res_cout, res_sum}, exp_r);
    end
    op_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL stall_release: valid=%0b busy=%0b required 0 0", res_valid, busy);
    end
    errs = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b0 || busy !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL stall_no_second_result: %0d cycles busy/valid required 0", errs);
    end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] s;
    logic         co, ov;
    int           lat;
    int           errs;
    res_ready = 1'b1;
    wait_idle();
    op_a = $urandom; op_b = $urandom; op_sub = 1'b0; op_cin = 1'b1; op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || op_ready !== 1'b1 || {add_a, add_b, add_cin} !== 17'd0) begin
      bad++; $display("FAIL abort_immediate: busy=%0b valid=%0b ready=%0b add=%h required 0 0 1 0",
                      busy, res_valid, op_ready, {add_a, add_b, add_cin});
    end
    errs = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (res_valid !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL abort_no_result: %0d cycles valid required 0", errs);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn(32'd1, 32'd1, 1'b0, 1'b0, s, co, ov, lat);
    total++;
    if (lat !== NBYTES || s !== 32'd2 || co !== 1'b0 || ov !== 1'b0) begin
      bad++; $display("FAIL abort_after: got lat=%0d sum=%h cout=%0b ovf=%0b required %0d 00000002 0 0",
                      lat, s, co, ov, NBYTES);
    end
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] exp_q [$];
    int           acc_cyc [$];
    logic [W+1:0] exp_r;
    int           cyc;
    int           got;
    logic         will_acc;
    res_ready = 1'b1;
    wait_idle();
    op_a = rnd_word(); op_b = rnd_word();
    op_sub = 1'($urandom_range(0, 1)); op_cin = 1'($urandom_range(0, 1));
    op_valid = 1'b1;
    cyc = 0;
    got = 0;
    repeat (40) begin
      if (res_valid && res_ready) begin
        got++;
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_result: unexpected result %h", {res_ovf, res_cout, res_sum});
        end else begin
          exp_r = exp_q.pop_front();
          if ({res_ovf, res_cout, res_sum} !== exp_r) begin
            bad++; $display("FAIL b2b_result: got %h required %h", {res_ovf, res_cout, res_sum}, exp_r);
          end
        end
      end
      will_acc = op_ready && op_valid;
      if (will_acc) begin
        exp_q.push_back(ref_model(op_a, op_b, op_sub, op_cin));
        acc_cyc.push_back(cyc);
      end
      @(posedge clk); #1;
      cyc++;
      if (will_acc) begin
        op_a = rnd_word(); op_b = rnd_word();
        op_sub = 1'($urandom_range(0, 1)); op_cin = 1'($urandom_range(0, 1));
      end
    end
    op_valid = 1'b0;
    total++;
    if (acc_cyc.size() < 6 || got < acc_cyc.size() - 1) begin
      bad++; $display("FAIL b2b_count: accepts=%0d results=%0d required >=6 and results>=accepts-1",
                      acc_cyc.size(), got);
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      total++;
      if (acc_cyc[i] - acc_cyc[i-1] != NBYTES + 2) begin
        bad++; $display("FAIL b2b_interval%0d: got %0d required %0d", i, acc_cyc[i] - acc_cyc[i-1], NBYTES + 2);
      end
    end
    repeat (NBYTES + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
